chart_streamer: RTL and testbench

Parametrised, time-sequenced successor to the static song loader. On a start request it selects one of `NUM_SONGS` stored charts and plays it out one step at a time, presenting that step's note bits for `LANES` lanes every `TICK_DIV` clocks. It tracks remaining notes and signals completion. It sits between the menu/song-select logic and the note-scroll and hit-judgement blocks.

---
 rtl/chart_pkg.sv | 25 ++
 rtl/chart_rom.sv | 63 ++++++
 rtl/chart_streamer.sv | 153 +++++++++++++++
 tb/tb_chart_streamer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/chart_pkg.sv
// Shared definitions for the chart streamer: song IDs, per-song note totals,
// FSM state encoding and a popcount helper.
package chart_pkg;

    localparam logic [4:0] SONG_TAKE_ON_ME  = 5'd3;
    localparam logic [4:0] SONG_TTFAF       = 5'd15;
    localparam int         TOTAL_TAKE_ON_ME = 42;
    localparam int         TOTAL_TTFAF      = 90;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_PLAY  = 3'd2,
        S_PAUSE = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    function automatic int popcount(input logic [31:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 32; i++) n += int'(v[i]);
        return n;
    endfunction

endpackage

// File: rtl/chart_rom.sv
// Registered chart lookup: (song, step) -> lane word, plus the song's note total.
// Each lane chart is stored MSB-first: bit CHART_LEN-1 is step 0.
module chart_rom
    import chart_pkg::*;
#(
    parameter int LANES     = 3,
    parameter int CHART_LEN = 100,
    parameter int SEL_W     = 5,
    parameter int CNT_W     = 8,
    parameter int ADDR_W    = $clog2(CHART_LEN) + 1
) (
    input  logic              clk,
    input  logic [SEL_W-1:0]  song,
    input  logic [ADDR_W-1:0] step,
    output logic [LANES-1:0]  word,
    output logic [CNT_W-1:0]  total
);

    localparam int IDX_W = $clog2(CHART_LEN);

    // Steps 0..9 are lead-in silence for both songs.
    // Chart 0: single notes on even steps 10..92, cycling red/yellow/blue.
    // Chart 1: repeating red+blue chord, yellow, rest.
    function automatic logic [CHART_LEN-1:0] lane_chart(input int chart, input int lane);
        logic [CHART_LEN-1:0] v;
        v = '0;
        for (int s = 10; s < CHART_LEN; s++) begin
            if (chart == 0) begin
                if (s <= 92 && s % 2 == 0 && lane == (s / 2) % 3) v[CHART_LEN-1-s] = 1'b1;
            end else begin
                if ((s % 3 == 0 && (lane == 0 || lane == 2)) || (s % 3 == 1 && lane == 1))
                    v[CHART_LEN-1-s] = 1'b1;
            end
        end
        return v;
    endfunction

    logic             is_tom;
    logic             is_ttfaf;
    logic             in_range;
    logic [IDX_W-1:0] bit_idx;
    logic [LANES-1:0] word_next;

    assign is_tom   = (song == SEL_W'(SONG_TAKE_ON_ME));
    assign is_ttfaf = (song == SEL_W'(SONG_TTFAF));
    assign in_range = (step < ADDR_W'(CHART_LEN));
    assign bit_idx  = IDX_W'(CHART_LEN - 1 - int'(step));

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        localparam logic [CHART_LEN-1:0] TOM_CHART   = lane_chart(0, l);
        localparam logic [CHART_LEN-1:0] TTFAF_CHART = lane_chart(1, l);
        assign word_next[l] = in_range &
                              ((is_tom & TOM_CHART[bit_idx]) | (is_ttfaf & TTFAF_CHART[bit_idx]));
    end

    always_ff @(posedge clk) begin
        word <= word_next;
        if (is_tom)        total <= CNT_W'(TOTAL_TAKE_ON_ME);
        else if (is_ttfaf) total <= CNT_W'(TOTAL_TTFAF);
        else               total <= '0;
    end

endmodule

// File: rtl/chart_streamer.sv
// Plays a stored chart one step every TICK_DIV clocks, tracking remaining notes.
// All outputs are registered; state is exported on state_dbg.
module chart_streamer
    import chart_pkg::*;
#(
    parameter int LANES     = 3,
    parameter int CHART_LEN = 100,
    parameter int SEL_W     = 5,
    parameter int TICK_DIV  = 4,
    parameter int CNT_W     = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [SEL_W-1:0]             song_select,
    input  logic                         start,
    input  logic                         pause,
    input  logic                         abort,
    output logic [LANES-1:0]             lane_notes,
    output logic                         step_valid,
    output logic [$clog2(CHART_LEN)-1:0] step_index,
    output logic [CNT_W-1:0]             total_notes,
    output logic [CNT_W-1:0]             notes_remaining,
    output logic                         busy,
    output logic                         done,
    output logic [2:0]                   state_dbg
);

    localparam int STEP_W = $clog2(CHART_LEN);
    localparam int ADDR_W = STEP_W + 1;
    localparam int DIV_W  = $clog2(TICK_DIV);

    localparam logic [2:0] ST_IDLE  = S_IDLE;
    localparam logic [2:0] ST_LOAD  = S_LOAD;
    localparam logic [2:0] ST_PLAY  = S_PLAY;
    localparam logic [2:0] ST_PAUSE = S_PAUSE;
    localparam logic [2:0] ST_DONE  = S_DONE;

    logic [2:0]        state;
    logic [2:0]        state_next;
    logic [SEL_W-1:0]  song_q;
    logic [SEL_W-1:0]  rom_song;
    logic [DIV_W-1:0]  div;
    logic [ADDR_W-1:0] rom_step;
    logic [LANES-1:0]  rom_word;
    logic [CNT_W-1:0]  rom_total;
    logic              playing;
    logic              wrap;
    logic              last_step;

    function automatic logic [CNT_W-1:0] after_step(input logic [CNT_W-1:0] remaining,
                                                    input logic [LANES-1:0] w);
        int pc;
        pc = popcount(32'(w));
        if (pc >= int'(remaining)) return '0;
        return remaining - CNT_W'(pc);
    endfunction

    assign playing   = (state == ST_PLAY) || (state == ST_PAUSE);
    assign wrap      = (div == DIV_W'(TICK_DIV - 1));
    assign last_step = (step_index == STEP_W'(CHART_LEN - 1));
    assign state_dbg = state;

    // The ROM is addressed one step ahead so the next word is ready at the divider wrap;
    // while waiting for start it follows song_select so LOAD sees the new song's data.
    assign rom_song = (state == ST_IDLE || state == ST_DONE) ? song_select : song_q;
    assign rom_step = playing ? ADDR_W'(step_index) + ADDR_W'(1) : '0;

    chart_rom #(
        .LANES    (LANES),
        .CHART_LEN(CHART_LEN),
        .SEL_W    (SEL_W),
        .CNT_W    (CNT_W),
        .ADDR_W   (ADDR_W)
    ) u_rom (
        .clk  (clk),
        .song (rom_song),
        .step (rom_step),
        .word (rom_word),
        .total(rom_total)
    );

    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: if (start) state_next = ST_LOAD;
                ST_LOAD:          state_next = (rom_total == '0) ? ST_DONE : ST_PLAY;
                ST_PLAY, ST_PAUSE: begin
                    if (pause)                  state_next = ST_PAUSE;
                    else if (wrap && last_step) state_next = ST_DONE;
                    else                        state_next = ST_PLAY;
                end
                default:          state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ST_IDLE;
            song_q          <= '0;
            div             <= '0;
            lane_notes      <= '0;
            step_valid      <= 1'b0;
            step_index      <= '0;
            total_notes     <= '0;
            notes_remaining <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            state      <= state_next;
            busy       <= (state_next == ST_LOAD) || (state_next == ST_PLAY) ||
                          (state_next == ST_PAUSE);
            done       <= (state_next == ST_DONE);
            step_valid <= 1'b0;
            if (abort) begin
                div             <= '0;
                lane_notes      <= '0;
                step_index      <= '0;
                notes_remaining <= '0;
            end else if ((state == ST_IDLE || state == ST_DONE) && start) begin
                song_q <= song_select;
            end else if (state == ST_LOAD) begin
                // Step 0 is emitted on the LOAD->PLAY edge, so the divider restarts at 0.
                total_notes     <= rom_total;
                notes_remaining <= rom_total;
                div             <= '0;
                step_index      <= '0;
                lane_notes      <= '0;
                if (rom_total != '0) begin
                    lane_notes      <= rom_word;
                    step_valid      <= 1'b1;
                    notes_remaining <= after_step(rom_total, rom_word);
                end
            end else if (playing && !pause) begin
                if (wrap) begin
                    div <= '0;
                    if (!last_step) begin
                        step_index      <= step_index + STEP_W'(1);
                        lane_notes      <= rom_word;
                        step_valid      <= 1'b1;
                        notes_remaining <= after_step(notes_remaining, rom_word);
                    end
                end else begin
                    div <= div + DIV_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_chart_streamer.sv
// Self-checking bench for chart_streamer: step schedule and note accounting are
// predicted from the chart definitions and timing rules, then compared per step.
module tb_chart_streamer;

    localparam int LANES     = 3;
    localparam int CHART_LEN = 100;
    localparam int SEL_W     = 5;
    localparam int TICK_DIV  = 4;
    localparam int CNT_W     = 8;
    localparam int STEP_W    = $clog2(CHART_LEN);
    localparam int EW        = STEP_W + LANES + CNT_W;

    logic                clk = 1'b0;
    logic                reset;
    logic [SEL_W-1:0]    song_select;
    logic                start;
    logic                pause;
    logic                abort;
    logic [LANES-1:0]    lane_notes;
    logic                step_valid;
    logic [STEP_W-1:0]   step_index;
    logic [CNT_W-1:0]    total_notes;
    logic [CNT_W-1:0]    notes_remaining;
    logic                busy;
    logic                done;
    logic [2:0]          state_dbg;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [EW-1:0] exp_q[$];
    int            exp_cyc_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    chart_streamer #(
        .LANES(LANES), .CHART_LEN(CHART_LEN), .SEL_W(SEL_W),
        .TICK_DIV(TICK_DIV), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .song_select(song_select), .start(start),
        .pause(pause), .abort(abort), .lane_notes(lane_notes), .step_valid(step_valid),
        .step_index(step_index), .total_notes(total_notes),
        .notes_remaining(notes_remaining), .busy(busy), .done(done), .state_dbg(state_dbg)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // ---------------- reference model ----------------
    function automatic int ref_total(input int sel);
        if (sel == 15) return 90;
        if (sel == 3)  return 42;
        return 0;
    endfunction

    function automatic logic [LANES-1:0] ref_word(input int sel, input int s);
        logic [LANES-1:0] w;
        w = '0;
        if (sel == 15 && s >= 10) begin
            if (s % 3 == 0)      w = 3'b101;
            else if (s % 3 == 1) w = 3'b010;
        end else if (sel == 3 && s >= 10 && s <= 92 && s % 2 == 0) begin
            w = 3'b001 << ((s / 2) % 3);
        end
        return w;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_lane"},  lane_notes, 0);
        check({tag, "_valid"}, step_valid, 0);
        check({tag, "_index"}, step_index, 0);
        check({tag, "_rem"},   notes_remaining, 0);
        check({tag, "_busy"},  busy, 0);
        check({tag, "_done"},  done, 0);
        check({tag, "_state"}, state_dbg, 0);
    endtask

    // ---------------- driver + scoreboard ----------------
    // pause_len > 0 holds pause high for pause_len cycles starting pause_off cycles
    // after the first step; abort_step >= 0 aborts (with start) at that step.
    task automatic run_song(input int sel, input int pause_off, input int pause_len,
                            input int abort_step, input bit poke_start);
        int t, p, rem, tot, done_cyc, budget, sum_obs, got_steps, e_cyc, ec;
        logic [EW-1:0] e;
        tot = ref_total(sel);
        exp_q.delete();
        exp_cyc_q.delete();
        p = 0;
        rem = tot;
        sum_obs = 0;
        got_steps = 0;

        song_select = SEL_W'(sel);
        start = 1'b1;
        t = cyc;
        tick();
        start = 1'b0;
        song_select = SEL_W'($urandom_range(0, 31));
        check("load_state", state_dbg, 1);
        check("load_busy", busy, 1);

        p = t + 2 + pause_off;
        if (tot != 0) begin
            for (int k = 0; k < CHART_LEN; k++) begin
                rem = rem - $countones(ref_word(sel, k));
                if (rem < 0) rem = 0;
                e_cyc = t + 2 + k * TICK_DIV;
                exp_q.push_back({STEP_W'(k), ref_word(sel, k), CNT_W'(rem)});
                exp_cyc_q.push_back(e_cyc + ((pause_len > 0 && e_cyc > p) ? pause_len : 0));
            end
            done_cyc = t + 2 + CHART_LEN * TICK_DIV + pause_len;
        end else begin
            done_cyc = t + 2;
        end

        budget = 0;
        while (budget < 1000) begin
            if (step_valid) begin
                got_steps++;
                sum_obs += $countones(lane_notes);
                if (exp_q.size() == 0) begin
                    check("extra_step", 1, 0);
                end else begin
                    e  = exp_q.pop_front();
                    ec = exp_cyc_q.pop_front();
                    check("step_index", step_index, e[EW-1 -: STEP_W]);
                    check("lane_notes", lane_notes, e[CNT_W +: LANES]);
                    check("notes_rem", notes_remaining, e[CNT_W-1:0]);
                    check("step_cycle", cyc, ec);
                end
                if (abort_step >= 0 && int'(step_index) == abort_step) begin
                    abort = 1'b1;
                    start = 1'b1;
                    tick();
                    abort = 1'b0;
                    start = 1'b0;
                    check_idle_outputs("abort");
                    check("abort_total", total_notes, tot);
                    return;
                end
            end
            if (done) break;
            pause = (pause_len > 0 && cyc >= p && cyc < p + pause_len);
            start = poke_start && (cyc == t + 50 || cyc == t + 200);
            if (start) song_select = SEL_W'($urandom_range(0, 31));
            tick();
            budget++;
        end
        pause = 1'b0;
        start = 1'b0;
        if (budget >= 1000) check("timeout", 0, 1);

        check("done_flag", done, 1);
        check("done_cycle", cyc, done_cyc);
        check("done_state", state_dbg, 4);
        check("done_busy", busy, 0);
        check("step_count", got_steps, (tot != 0) ? CHART_LEN : 0);
        check("total_notes", total_notes, tot);
        check("rem_end", notes_remaining, 0);
        check("popcount_sum", sum_obs, tot);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int sel, poff, plen;
        reset = 1'b1;
        start = 1'b0;
        pause = 1'b0;
        abort = 1'b0;
        song_select = '0;
        repeat (3) tick();
        reset = 1'b0;
        check_idle_outputs("reset");
        check("reset_total", total_notes, 0);
        tick();

        run_song(15, 0, 0, -1, 1'b0);
        run_song(3, 100, 10, -1, 1'b1);
        run_song(7, 0, 0, -1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            check("unknown_no_step", step_valid, 0);
            check("unknown_done", done, 1);
            tick();
        end

        run_song(15, 0, 0, 50, 1'b0);
        run_song(15, 0, 0, -1, 1'b0);

        for (int i = 0; i < 4; i++) begin
            case ($urandom_range(0, 2))
                0:       sel = 3;
                1:       sel = 15;
                default: sel = $urandom_range(0, 31);
            endcase
            poff = ($urandom_range(0, 1) == 1) ? TICK_DIV * $urandom_range(2, 94)
                                               : $urandom_range(5, 380);
            plen = $urandom_range(0, 12);
            run_song(sel, poff, plen, -1, 1'($urandom_range(0, 1)));
        end

        song_select = 5'd15;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (30) tick();
        pause = 1'b1;
        repeat (4) tick();
        check("pause_state", state_dbg, 3);
        check("pause_busy", busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        pause = 1'b0;
        check_idle_outputs("reset_in_pause");
        check("reset_in_pause_total", total_notes, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
